// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit: funct3 codes,
// FSM state encoding, per-op control bundle and the word sign-extension helper.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // Control captured on accept and consumed by the sign-fix on the DONE load
  typedef struct packed {
    logic [2:0] op;
    logic       word;
    logic       neg_q;
    logic       neg_r;
    logic       special;
  } mdu_ctl_t;

  function automatic logic [63:0] sext_w(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not borrow.
module mdu_div_step #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] div_i,
  input  logic         bit_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, div_i};
    q_o     = ~diff[W];
    rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit, one op in flight.
// Build option MDU_FAST_MUL_EN: multiplies complete with a single-cycle '*' in one BUSY cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  mdu_ctl_t         ctl_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [PW-1:0]    mc_q;
  logic [PW-1:0]    acc_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             word_en, is_mul, src1_sgn, src2_sgn, neg1, neg2;
  logic [XLEN-1:0]  op1, op2, mag1, mag2;
  logic             div_zero, div_ovf;
  logic [XLEN-1:0]  spec_res;
  logic [XLEN-1:0]  a_d;
  logic [CNT_W-1:0] cnt_d;
  mdu_ctl_t         ctl_d;

  logic [XLEN-1:0]  rem_nxt;
  logic             q_bit;
  logic [PW-1:0]    prod_fix;
  logic [XLEN-1:0]  quo_fix, rem_fix, res_d;

  // Operand prep for the accept edge: extension, magnitudes, special cases
  always_comb begin
    word_en  = (XLEN == 64) && in_word;
    is_mul   = !in_op[2];
    src1_sgn = (in_op == MDU_MULH) || (in_op == MDU_MULHSU) ||
               (in_op == MDU_DIV)  || (in_op == MDU_REM);
    src2_sgn = (in_op == MDU_MULH) || (in_op == MDU_DIV) || (in_op == MDU_REM);
    if (word_en && is_mul) begin
      src1_sgn = 1'b0;
      src2_sgn = 1'b0;
    end
    op1 = in_src1;
    op2 = in_src2;
    if (word_en) begin
      op1 = src1_sgn ? XLEN'(sext_w(in_src1[31:0])) : XLEN'({32'b0, in_src1[31:0]});
      op2 = src2_sgn ? XLEN'(sext_w(in_src2[31:0])) : XLEN'({32'b0, in_src2[31:0]});
    end
    neg1 = src1_sgn && op1[XLEN-1];
    neg2 = src2_sgn && op2[XLEN-1];
    mag1 = neg1 ? -op1 : op1;
    mag2 = neg2 ? -op2 : op2;

    div_zero = !is_mul && (word_en ? (in_src2[31:0] == 32'd0) : (in_src2 == '0));
    div_ovf  = !is_mul && !in_op[0] &&
               (word_en ? ((in_src1[31:0] == 32'h8000_0000) && (in_src2[31:0] == 32'hFFFF_FFFF))
                        : ((in_src1 == XMIN) && (in_src2 == '1)));
    spec_res = '0;
    if (div_zero) begin
      spec_res = in_op[1] ? in_src1 : '1;
    end else if (div_ovf) begin
      spec_res = in_op[1] ? '0 : (word_en ? XLEN'(sext_w(32'h8000_0000)) : XMIN);
    end
    if (word_en) spec_res = XLEN'(sext_w(spec_res[31:0]));

    // Word divides left-justify the dividend so 32 steps consume it entirely
    a_d   = (word_en && !is_mul) ? XLEN'({mag1[31:0], 32'b0}) : mag1;
    cnt_d = word_en ? CNT_W'(31) : CNT_W'(XLEN - 1);

    ctl_d.op      = in_op;
    ctl_d.word    = word_en;
    ctl_d.neg_q   = neg1 ^ neg2;
    ctl_d.neg_r   = neg1;
    ctl_d.special = div_zero || div_ovf;
  end

  mdu_div_step #(.W(XLEN)) u_div_step (
    .rem_i (acc_q[XLEN-1:0]),
    .div_i (b_q),
    .bit_i (a_q[XLEN-1]),
    .rem_o (rem_nxt),
    .q_o   (q_bit)
  );

  // Sign-fix and result select for the DONE load
  always_comb begin
    prod_fix = ctl_q.neg_q ? -acc_q : acc_q;
    quo_fix  = ctl_q.neg_q ? -a_q : a_q;
    rem_fix  = ctl_q.neg_r ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    if (ctl_q.special) begin
      res_d = acc_q[XLEN-1:0];
    end else if (!ctl_q.op[2]) begin
      res_d = ((ctl_q.op == MDU_MUL) || ctl_q.word) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
    end else if (!ctl_q.op[1]) begin
      res_d = quo_fix;
    end else begin
      res_d = rem_fix;
    end
    if (ctl_q.word) res_d = XLEN'(sext_w(res_d[31:0]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MDU_IDLE;
      cnt_q        <= '0;
      ctl_q        <= '0;
      tag_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mc_q         <= '0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (flush) begin
      state_q     <= MDU_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (in_valid) begin
            ctl_q   <= ctl_d;
            tag_q   <= in_tag;
            a_q     <= a_d;
            b_q     <= mag2;
            mc_q    <= PW'(mag2);
            acc_q   <= ctl_d.special ? PW'(spec_res) : '0;
            cnt_q   <= cnt_d;
            state_q <= ctl_d.special ? MDU_DONE : MDU_BUSY;
          end
        end
        MDU_BUSY: begin
          if (ctl_q.op[2]) begin
            a_q   <= {a_q[XLEN-2:0], q_bit};
            acc_q <= PW'(rem_nxt);
          end else if (FAST_MUL) begin
            acc_q <= PW'(a_q) * PW'(b_q);
          end else begin
            if (a_q[0]) acc_q <= acc_q + mc_q;
            a_q  <= a_q >> 1;
            mc_q <= mc_q << 1;
          end
          if ((cnt_q == '0) || (FAST_MUL && !ctl_q.op[2])) begin
            state_q <= MDU_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        MDU_DONE: begin
          if (!out_valid_q) begin
            out_valid_q  <= 1'b1;
            out_result_q <= res_d;
            out_tag_q    <= tag_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= MDU_IDLE;
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == MDU_IDLE);
  assign busy       = (state_q != MDU_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, handshake/flush/reset
// sequences and a random regression against a behavioural reference model.
module tb_mdu_iter;
  import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk, rst, flush, in_valid, in_ready, in_word;
  logic [2:0]  in_op;
  logic [63:0] in_src1, in_src2, out_result;
  logic [3:0]  in_tag, out_tag;
  logic        out_valid, out_ready, busy;

  int errors = 0;
  int checks = 0;
  logic [63:0] last_res;

  mdu_iter #(.XLEN(64), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_word(in_word), .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  tag;
    logic [63:0] exp;
    logic        spec;
  } vec_t;

  vec_t vecs[21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [2:0] op, input logic w, input logic spec);
    if (spec) return 1;
    if (!op[2] && FAST) return 2;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] pa, pb, pr;
    logic [63:0]  r;
    logic [31:0]  a32, b32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    r = '0;
    r32 = '0;
    if (!op[2]) begin
      if (w) begin
        r32 = a32 * b32;
        r = {{32{r32[31]}}, r32};
      end else begin
        pa = ((op == MDU_MULH) || (op == MDU_MULHSU)) ? {{64{a[63]}}, a} : {64'b0, a};
        pb = (op == MDU_MULH) ? {{64{b[63]}}, b} : {64'b0, b};
        pr = pa * pb;
        r = (op == MDU_MUL) ? pr[63:0] : pr[127:64];
      end
    end else if (w) begin
      if (b32 == 32'd0) r32 = op[1] ? a32 : 32'hFFFF_FFFF;
      else if (!op[0] && (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF)) r32 = op[1] ? 32'd0 : a32;
      else if (op == MDU_DIV) r32 = $signed(a32) / $signed(b32);
      else if (op == MDU_DIVU) r32 = a32 / b32;
      else if (op == MDU_REM) r32 = $signed(a32) % $signed(b32);
      else r32 = a32 % b32;
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) r = op[1] ? a : '1;
      else if (!op[0] && (a == 64'h8000_0000_0000_0000) && (b == '1)) r = op[1] ? 64'd0 : a;
      else if (op == MDU_DIV) r = $signed(a) / $signed(b);
      else if (op == MDU_DIVU) r = a / b;
      else if (op == MDU_REM) r = $signed(a) % $signed(b);
      else r = a % b;
    end
    return r;
  endfunction

  // Issue one op with out_ready=1; checks result, tag and (if exp_lat>=0) edges to out_valid
  task automatic do_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [3:0] tag, input logic [63:0] exp,
                       input int exp_lat, input string name);
    int lat;
    int waitc;
    waitc = 0;
    while (!in_ready && waitc < 200) begin tick(); waitc++; end
    in_op = op; in_word = w; in_src1 = a; in_src2 = b; in_tag = tag; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 300) begin tick(); lat++; end
    chk({name, " valid"}, 64'(out_valid), 64'd1);
    chk({name, " result"}, out_result, exp);
    chk({name, " tag"}, 64'(out_tag), 64'(tag));
    if (exp_lat >= 0) chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    last_res = exp;
    tick();
  endtask

  initial begin
    int n;
    logic saw;
    logic [2:0] rop;
    logic rw;
    logic [63:0] ra, rb;
    int sel;

    vecs[0]  = '{MDU_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 4'h5, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0};
    vecs[1]  = '{MDU_DIVU,   1'b0, 64'h1234, 64'd0, 4'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[2]  = '{MDU_REM,    1'b0, 64'd7, 64'd0, 4'h2, 64'd7, 1'b1};
    vecs[3]  = '{MDU_DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'h3, 64'h8000_0000_0000_0000, 1'b1};
    vecs[4]  = '{MDU_REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'h4, 64'd0, 1'b1};
    vecs[5]  = '{MDU_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'h6, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[6]  = '{MDU_MUL,    1'b1, 64'h7FFF_FFFF, 64'd2, 4'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[7]  = '{MDU_REMU,   1'b0, 64'd10, 64'd4, 4'h8, 64'd2, 1'b0};
    vecs[8]  = '{MDU_MUL,    1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 4'h9, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0};
    vecs[9]  = '{MDU_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'hA, 64'd0, 1'b0};
    vecs[10] = '{MDU_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'hB, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[11] = '{MDU_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 4'hC, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[12] = '{MDU_DIV,    1'b1, 64'hDEAD_BEEF_FFFF_FFEC, 64'd3, 4'hD, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0};
    vecs[13] = '{MDU_DIVU,   1'b1, 64'hFFFF_FFFF, 64'h1_0000_0000, 4'hE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[14] = '{MDU_REM,    1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 4'hF, 64'd0, 1'b1};
    vecs[15] = '{MDU_DIV,    1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 4'h0, 64'hFFFF_FFFF_8000_0000, 1'b1};
    vecs[16] = '{MDU_REMU,   1'b1, 64'h1234_5678_8000_0007, 64'd0, 4'h1, 64'hFFFF_FFFF_8000_0007, 1'b1};
    vecs[17] = '{MDU_MULH,   1'b0, 64'h4000_0000_0000_0000, 64'd4, 4'h2, 64'd1, 1'b0};
    vecs[18] = '{MDU_DIVU,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 4'h3, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[19] = '{MDU_REMU,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 4'h4, 64'hF, 1'b0};
    vecs[20] = '{MDU_MULHU,  1'b1, 64'hFFFF_FFFF, 64'd3, 4'h5, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_word = 1'b0;
    in_src1 = '0; in_src2 = '0; in_tag = '0; out_ready = 1'b1; last_res = '0;
    tick();
    tick();
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_result", out_result, 64'd0);
    chk("reset out_tag", 64'(out_tag), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 21; i++) begin
      do_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp,
            lat_of(vecs[i].op, vecs[i].w, vecs[i].spec), $sformatf("vec%0d", i));
    end

    // Output stall with a new request already waiting
    out_ready = 1'b0;
    in_op = MDU_MUL; in_word = 1'b0; in_src1 = 64'd6; in_src2 = 64'd7; in_tag = 4'h9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 300) begin tick(); n++; end
    chk("stall valid", 64'(out_valid), 64'd1);
    in_op = MDU_REMU; in_src1 = 64'd10; in_src2 = 64'd4; in_tag = 4'h3; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall result", out_result, 64'd42);
      chk("stall tag", 64'(out_tag), 64'h9);
      chk("stall in_ready", 64'(in_ready), 64'd0);
      chk("stall held valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("handshake drops valid", 64'(out_valid), 64'd0);
    chk("handshake in_ready", 64'(in_ready), 64'd1);
    chk("no accept on handshake", 64'(busy), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("accept after handshake", 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 300) begin tick(); n++; end
    chk("queued result", out_result, 64'd2);
    chk("queued tag", 64'(out_tag), 64'h3);
    last_res = 64'd2;
    tick();

    // Flush beats a simultaneous accept
    in_op = MDU_DIV; in_word = 1'b0; in_src1 = 64'd100; in_src2 = 64'd7; in_tag = 4'h1;
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush blocks accept", 64'(busy), 64'd0);

    // Flush in BUSY cycle 20
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    chk("busy before flush", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    chk("flush keeps out_result", out_result, last_res);
    saw = 1'b0;
    for (int i = 0; i < 80; i++) begin tick(); if (out_valid) saw = 1'b1; end
    chk("no valid after flush", 64'(saw), 64'd0);
    do_op(MDU_REMU, 1'b0, 64'd10, 64'd4, 4'h6, 64'd2, 65, "post-flush remu");

    // Flush while the result waits in DONE
    out_ready = 1'b0;
    in_op = MDU_DIVU; in_word = 1'b0; in_src1 = 64'd9; in_src2 = 64'd0; in_tag = 4'h2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("done valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("done flush valid", 64'(out_valid), 64'd0);
    chk("done flush in_ready", 64'(in_ready), 64'd1);
    chk("done flush keeps result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);

    // Async reset mid-op
    in_op = MDU_DIV; in_src1 = 64'd1000; in_src2 = 64'd7; in_tag = 4'hA; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst out_result", out_result, 64'd0);
    chk("arst out_tag", 64'(out_tag), 64'd0);
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst in_ready", 64'(in_ready), 64'd1);
    tick();
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 70; i++) begin tick(); if (out_valid) saw = 1'b1; end
    chk("no valid after arst", 64'(saw), 64'd0);
    do_op(MDU_DIV, 1'b0, 64'd1000, 64'd7, 4'hA, 64'd142, 65, "post-arst div");

    // Random regression against the reference model
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      rw  = 1'($urandom_range(0, 1));
      ra  = {$urandom(), $urandom()};
      rb  = {$urandom(), $urandom()};
      sel = int'($urandom_range(0, 7));
      if (sel == 0) rb = 64'd0;
      else if (sel == 1) begin ra = 64'h8000_0000_0000_0000; rb = '1; end
      else if (sel == 2) begin ra[63:32] = $urandom(); ra[31:0] = 32'h8000_0000; rb = 64'hFFFF_FFFF; end
      else if (sel == 3) rb = 64'($urandom_range(1, 20));
      do_op(rop, rw, ra, rb, 4'(i), ref_mdu(rop, rw, ra, rb), -1, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
